// File: rtl/fifo_rd_adapter.sv
// Pops an upstream FIFO (1-cycle read latency) into a valid/ready packet stream; word appears 2 edges after its pop.
// 2-entry skid buffer: pops stop once buffered + in-flight words reach 2, so m_ready=0 never drops or duplicates data.
module fifo_rd_adapter #(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic [15:0]           pkt_cnt
);

   localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] tail;
   logic [1:0]            occ;
   logic                  infl;
   logic [BW-1:0]         beat;
   logic                  xfer;
   logic [1:0]            committed;
   logic                  wr_slot;

   assign xfer       = m_valid & m_ready;
   assign committed  = occ + {1'b0, infl};
   assign fifo_rd_en = rstn & ~fifo_empty & ((committed < 2'd2) | xfer);
   assign m_valid    = (occ != 2'd0);
   assign m_data     = head;
   assign m_last     = m_valid & (beat == LAST_BEAT);

   // The arriving word goes behind whatever is still buffered after this edge's transfer.
   assign wr_slot = ((occ - {1'b0, xfer}) != 2'd0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         occ  <= 2'd0;
         infl <= 1'b0;
         head <= '0;
         tail <= '0;
      end else begin
         infl <= fifo_rd_en;
         occ  <= occ + {1'b0, infl} - {1'b0, xfer};
         if (xfer) begin
            head <= tail;
         end
         if (infl) begin
            if (wr_slot) begin
               tail <= fifo_data_out;
            end else begin
               head <= fifo_data_out;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat    <= '0;
         pkt_cnt <= 16'd0;
      end else if (xfer) begin
         if (m_last) begin
            beat    <= '0;
            pkt_cnt <= pkt_cnt + 16'd1;
         end else begin
            beat <= beat + BW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed + random bench: behavioural upstream FIFO, scoreboard of pushed words, packet model.
module tb_fifo_rd_adapter;

   localparam int PKT_LEN = 4;

   logic        clk;
   logic        rstn;
   logic        fifo_empty;
   logic        m_ready;
   logic [7:0]  fifo_data_out;
   logic        fifo_rd_en;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_last;
   logic [15:0] pkt_cnt;
   logic        u1_rd_en;
   logic [7:0]  u1_data;
   logic        u1_valid;
   logic        u1_last;
   logic [15:0] u1_pkt_cnt;

   fifo_rd_adapter #(.DATA_WIDTH(8), .PKT_LEN(PKT_LEN)) dut (
      .clk(clk), .rstn(rstn), .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
      .fifo_empty(fifo_empty), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .pkt_cnt(pkt_cnt)
   );

   fifo_rd_adapter #(.DATA_WIDTH(8), .PKT_LEN(1)) u1 (
      .clk(clk), .rstn(rstn), .fifo_rd_en(u1_rd_en), .fifo_data_out(fifo_data_out),
      .fifo_empty(fifo_empty), .m_data(u1_data), .m_valid(u1_valid), .m_ready(m_ready),
      .m_last(u1_last), .pkt_cnt(u1_pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          ncmp;
   int          nfail;
   logic [7:0]  src_q[$];
   logic [7:0]  exp_q[$];
   bit          rdy;
   int          tb_beat;
   logic [15:0] tb_pkt;
   int          pops;
   int          last_cnt;
   int          last_sum;
   int          u1_last_cnt;
   int          nstep;
   int          first_xfer;
   bit          s_rd;
   bit          s_xfer;
   bit          prev_stall;
   logic [7:0]  prev_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] w);
      src_q.push_back(w);
      exp_q.push_back(w);
   endtask

   // Inputs change just after the rising edge; outputs are sampled at the falling edge.
   task automatic step();
      logic [7:0] e;
      logic       exp_last;
      fifo_empty = (src_q.size() == 0);
      m_ready    = rdy;
      @(negedge clk);
      nstep++;
      s_rd   = fifo_rd_en;
      s_xfer = m_valid && m_ready;
      check("rd_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
      check("u1_rd_while_empty", {31'd0, u1_rd_en && fifo_empty}, 32'd0);
      check("occ_plus_infl_le2", {31'd0, (int'(dut.occ) + int'(dut.infl)) <= 2}, 32'd1);
      check("pkt_cnt", pkt_cnt, tb_pkt);
      check("u1_last_every_beat", u1_last, u1_valid);
      if (prev_stall) check("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (s_xfer) begin
         if (first_xfer < 0) first_xfer = nstep;
         if (exp_q.size() == 0) begin
            check("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
         end else begin
            e        = exp_q.pop_front();
            exp_last = (tb_beat == PKT_LEN - 1);
            check("data", m_data, e);
            check("u1_data", u1_data, e);
            check("last", m_last, exp_last);
            if (exp_last) begin
               tb_beat = 0;
               tb_pkt  = tb_pkt + 16'd1;
               last_cnt++;
               last_sum += int'(m_data);
            end else begin
               tb_beat++;
            end
            if (u1_last) u1_last_cnt++;
         end
      end
      if (s_rd) pops++;
      @(posedge clk);
      #1;
      if (s_rd && src_q.size() > 0) fifo_data_out = src_q.pop_front();
   endtask

   task automatic drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
      check(tag, exp_q.size(), 32'd0);
   endtask

   task automatic align_beat(input int target);
      int n;
      n = (target - tb_beat + PKT_LEN) % PKT_LEN;
      rdy = 1'b1;
      for (int i = 0; i < n; i++) push(8'hE0 + 8'(i));
      drain("align_drain", 50);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_valid"}, m_valid, 32'd0);
      check({tag, "_m_last"}, m_last, 32'd0);
      check({tag, "_m_data"}, m_data, 32'd0);
      check({tag, "_rd_en"}, fifo_rd_en, 32'd0);
      check({tag, "_pkt_cnt"}, pkt_cnt, 32'd0);
      check({tag, "_beat"}, dut.beat, 32'd0);
   endtask

   task automatic clear_model();
      src_q.delete();
      exp_q.delete();
      fifo_data_out = 8'd0;
      fifo_empty    = 1'b1;
      tb_beat       = 0;
      tb_pkt        = 16'd0;
      prev_stall    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed;
      ncmp = 0; nfail = 0; nstep = 0; pops = 0;
      last_cnt = 0; last_sum = 0; u1_last_cnt = 0; first_xfer = -1;
      rdy = 1'b1; m_ready = 1'b0;
      clear_model();
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #1 check_reset_outputs("por");
      check("por_u1_pkt_cnt", u1_pkt_cnt, 32'd0);
      for (int i = 0; i < 3; i++) step();
      check_reset_outputs("por_held");

      // Streaming after reset release, 10 words at full rate
      for (int i = 22; i <= 31; i++) push(8'(i));
      rstn = 1'b1;
      nstep = 0; first_xfer = -1; last_cnt = 0; last_sum = 0;
      drain("stream_drain", 40);
      check("stream_first_xfer_step", first_xfer, 32'd3);
      check("stream_no_bubbles", nstep, 32'd12);
      check("stream_last_count", last_cnt, 32'd2);
      check("stream_last_sum", last_sum, 32'd54);
      check("stream_pkt_cnt", pkt_cnt, 32'd2);

      // Backpressure: exactly two pops, then hold
      rdy = 1'b0; pops = 0;
      push(8'd22); push(8'd23); push(8'd24);
      for (int i = 0; i < 6; i++) begin
         step();
         if (m_valid) check("bp_hold_22", m_data, 32'd22);
      end
      check("bp_pops", pops, 32'd2);
      check("bp_rd_en_low", fifo_rd_en, 32'd0);
      check("bp_occ", dut.occ, 32'd2);
      rdy = 1'b1;
      drain("bp_drain", 20);
      check("bp_src_empty", src_q.size(), 32'd0);

      // Underflow mid-packet: beat must hold at 2, last only on the 4th word
      align_beat(0);
      last_cnt = 0; last_sum = 0;
      push(8'hA0); push(8'hA1);
      drain("gap_first_half", 20);
      for (int i = 0; i < 5; i++) step();
      check("gap_beat_hold", dut.beat, 32'd2);
      check("gap_valid_low", m_valid, 32'd0);
      check("gap_no_early_last", last_cnt, 32'd0);
      push(8'hA2); push(8'hA3);
      drain("gap_second_half", 20);
      check("gap_last_count", last_cnt, 32'd1);
      check("gap_last_word", last_sum, 32'hA3);

      // Random backpressure and upstream gaps over 1000 words
      pushed = 0;
      for (int i = 0; i < 20000 && (pushed < 1000 || exp_q.size() > 0); i++) begin
         if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
            push(8'($urandom));
            pushed++;
         end
         rdy = ($urandom_range(0, 3) != 0);
         step();
      end
      check("rand_all_words_out", exp_q.size(), 32'd0);
      check("rand_src_consumed", src_q.size(), 32'd0);

      // Asynchronous reset with two words buffered mid-packet
      align_beat(1);
      rdy = 1'b0;
      push(8'h5A); push(8'h5B); push(8'h5C); push(8'h5D);
      for (int i = 0; i < 4; i++) step();
      check("mid_occ_full", dut.occ, 32'd2);
      check("mid_beat", dut.beat, 32'd1);
      check("mid_head", {m_valid, m_data}, {1'b1, 8'h5A});
      #2 rstn = 1'b0;
      #1 check_reset_outputs("async_rst");
      check("async_rst_occ", dut.occ, 32'd0);
      check("async_rst_infl", dut.infl, 32'd0);
      check("async_rst_u1_pkt_cnt", u1_pkt_cnt, 32'd0);
      clear_model();
      for (int i = 0; i < 3; i++) step();
      check_reset_outputs("rst_held");
      rstn = 1'b1;

      // Restart: PKT_LEN=1 instance flags every beat; main instance restarts at beat 0
      rdy = 1'b1; nstep = 0; first_xfer = -1; u1_last_cnt = 0; last_cnt = 0;
      push(8'h01); push(8'h02); push(8'h03);
      drain("restart_drain", 20);
      check("restart_first_xfer_step", first_xfer, 32'd3);
      check("u1_pkt_cnt", u1_pkt_cnt, 32'd3);
      check("u1_last_count", u1_last_cnt, 32'd3);
      check("restart_pkt_cnt0", pkt_cnt, 32'd0);
      for (int i = 4; i <= 8; i++) push(8'(i));
      drain("restart_drain2", 20);
      check("restart_pkt_cnt", pkt_cnt, 32'd2);
      check("restart_last_count", last_cnt, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
